mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single external memory port between the fetch unit (instruction reads) and the LSU (data loads/stores driven by decode).
- Both requesters use the core's four-phase req/valid handshake:
  - the requester raises req and holds it;
  - the arbiter raises valid and holds it until req drops.
- The memory side uses the same four-phase handshake.
- Arbitration is round-robin. Each transaction has a timeout guard.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data bus width.
- BYTE_DATA_WIDTH, 4, byte-enable width (DATA_WIDTH/8).
- TIMEOUT_CYCLES, 255, maximum BUSY cycles before abort. Range 1..65535.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request; level, held until if_valid.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_valid  out  1  fetch data valid; held until if_req low.
- if_rdata  out  DATA_WIDTH  fetch read data.
- ls_req  in  1  LSU request; level.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_WIDTH  LSU address.
- ls_wdata  in  DATA_WIDTH  store data.
- ls_byte_enable  in  BYTE_DATA_WIDTH  LSU byte lanes.
- ls_valid  out  1  LSU transaction done; held until ls_req low.
- ls_rdata  out  DATA_WIDTH  load data; 0 for stores.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_byte_enable  out  BYTE_DATA_WIDTH  memory byte lanes; fetch always drives all ones.
- mem_valid  in  1  memory done; held until mem_req low.
- mem_rdata  in  DATA_WIDTH  memory read data.
- timeout_err  out  1  sticky flag, set on any timeout.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, last_grant=LS, counter=0.
  - All outputs 0, including latched address/data/byte-enable registers and timeout_err.
  - Reset mid-transaction abandons the transaction with no further handshake.
- All outputs are registered. No combinational path from any input to any output.
- State IDLE:
  - Neither req high: stay in IDLE.
  - One req high: grant that requester.
  - Both high: grant the requester that is not last_grant.
  - On a grant, at that edge:
    - latch the request fields: fetch forces we=0 and byte_enable all ones;
    - set owner and last_grant;
    - clear the counter;
    - set mem_req=1;
    - go to BUSY.
- State BUSY:
  - mem_* outputs are driven from the latched registers and stay stable.
  - The counter increments each cycle.
  - If mem_valid=1:
    - capture mem_rdata into the owner's rdata (0 if the access was a store);
    - mem_req goes to 0;
    - the owner's valid goes to 1;
    - go to RELEASE.
  - Else if counter == TIMEOUT_CYCLES-1:
    - mem_req goes to 0;
    - owner valid goes to 1 with rdata=0;
    - timeout_err is set;
    - go to RELEASE.
- State RELEASE:
  - Hold the owner's valid and rdata.
  - When the owner's req is 0 AND mem_valid is 0:
    - clear valid;
    - go to IDLE.
  - A new grant is possible on the next edge, so back-to-back transactions cost 1 idle cycle.
- Latency: req high before edge N → mem_req high after N. mem_valid high before edge M → requester valid high after M. Minimum from req to valid is 2 cycles.
- The non-owner's valid stays 0 throughout. Its req is simply left pending.
- Owner drops req during BUSY: ignored. The transaction still completes and valid pulses until req is seen low.
- mem_valid high while in IDLE (stale response): ignored.
- Fairness: under continuous requests from both sides, grants strictly alternate. Neither requester waits more than one transaction.
- Counter width is clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.

Decomposition:
- Shared package/config include holds:
  - state encodings ST_IDLE=0, ST_BUSY=1, ST_RELEASE=2;
  - owner encoding OWN_IF=0, OWN_LS=1;
  - the full byte-enable constant.
- One sub-module, rr_arbiter2: two requests plus last_grant in, one-hot grant out, purely combinational. It is kept separate for reuse by a future multi-port arbiter.
- FSM, latches and timeout counter live in mem_port_arbiter.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100; memory responds 3 cycles after mem_req with 0xDEADBEEF → mem_addr=0x100, mem_we=0, mem_byte_enable=0xF; if_valid=1 with if_rdata=0xDEADBEEF; returns to IDLE one cycle after if_req and mem_valid are both low.
- Simultaneous requests after reset: if_req=1 and ls_req=1 (store 0x55 to 0x200, byte_enable=0x1) → fetch is granted first. After fetch completes, the store is issued with mem_we=1, mem_wdata=0x55, mem_byte_enable=0x1, and ls_rdata=0 on completion.
- Continuous contention for 8 transactions: grants strictly alternate IF, LS, IF, …; each requester waits at most one transaction.
- Timeout with TIMEOUT_CYCLES=4 and mem_valid never asserted → mem_req drops after 4 BUSY cycles; ls_valid=1 with ls_rdata=0; timeout_err stays 1 afterwards.
- Asynchronous reset asserted mid-BUSY: all outputs 0 immediately, without waiting for a clock edge. After rst release, a new fetch completes normally.
- Stale or late mem_valid: in RELEASE, mem_valid held high for 2 extra cycles after if_req drops → no new grant until mem_valid is low; a pending ls_req is granted on the following edge.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, owner IDs and
// the all-lanes byte-enable pattern used for instruction fetches.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  localparam int unsigned BE_WIDTH = 4;
  localparam logic [BE_WIDTH-1:0] BE_FULL = '1;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant {ls, if}, preferring the
// requester that did not win last time when both are requesting.
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic       req_if,
  input  logic       req_ls,
  input  owner_t     last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (req_if && req_ls) begin
      if (last_grant == OWN_LS) grant = 2'b01;
      else                      grant = 2'b10;
    end else if (req_if) begin
      grant = 2'b01;
    end else if (req_ls) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one four-phase memory port between fetch and LSU with round-robin
// arbitration, registered outputs and a per-transaction timeout guard.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BYTE_DATA_WIDTH = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_req,
  input  logic [ADDR_WIDTH-1:0]      if_addr,
  output logic                       if_valid,
  output logic [DATA_WIDTH-1:0]      if_rdata,
  input  logic                       ls_req,
  input  logic                       ls_we,
  input  logic [ADDR_WIDTH-1:0]      ls_addr,
  input  logic [DATA_WIDTH-1:0]      ls_wdata,
  input  logic [BYTE_DATA_WIDTH-1:0] ls_byte_enable,
  output logic                       ls_valid,
  output logic [DATA_WIDTH-1:0]      ls_rdata,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  output logic [BYTE_DATA_WIDTH-1:0] mem_byte_enable,
  input  logic                       mem_valid,
  input  logic [DATA_WIDTH-1:0]      mem_rdata,
  output logic                       timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t                     state_q, state_d;
  owner_t                     owner_q, owner_d;
  owner_t                     last_q, last_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [1:0]                 grant;
  logic                       owner_req;

  logic                       mem_req_d, mem_we_d, if_valid_d, ls_valid_d, timeout_err_d;
  logic [ADDR_WIDTH-1:0]      mem_addr_d;
  logic [DATA_WIDTH-1:0]      mem_wdata_d, if_rdata_d, ls_rdata_d;
  logic [BYTE_DATA_WIDTH-1:0] mem_be_d;

  rr_arbiter2 u_rr (
    .req_if     (if_req),
    .req_ls     (ls_req),
    .last_grant (last_q),
    .grant      (grant)
  );

  assign owner_req = (owner_q == OWN_LS) ? ls_req : if_req;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    mem_req_d     = mem_req;
    mem_we_d      = mem_we;
    mem_addr_d    = mem_addr;
    mem_wdata_d   = mem_wdata;
    mem_be_d      = mem_byte_enable;
    if_valid_d    = if_valid;
    if_rdata_d    = if_rdata;
    ls_valid_d    = ls_valid;
    ls_rdata_d    = ls_rdata;
    timeout_err_d = timeout_err;

    case (state_q)
      ST_IDLE: begin
        if (grant[1]) begin
          owner_d     = OWN_LS;
          last_d      = OWN_LS;
          mem_we_d    = ls_we;
          mem_addr_d  = ls_addr;
          mem_wdata_d = ls_wdata;
          mem_be_d    = ls_byte_enable;
        end else if (grant[0]) begin
          owner_d     = OWN_IF;
          last_d      = OWN_IF;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_be_d    = '1;
        end
        if (grant != 2'b00) begin
          cnt_d     = '0;
          mem_req_d = 1'b1;
          state_d   = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        if (mem_valid || (cnt_q == CNT_LAST)) begin
          mem_req_d = 1'b0;
          state_d   = ST_RELEASE;
          // A timeout completes the transaction with zero data and latches the error.
          if (!mem_valid) timeout_err_d = 1'b1;
          if (owner_q == OWN_LS) begin
            ls_valid_d = 1'b1;
            ls_rdata_d = (mem_valid && !mem_we) ? mem_rdata : '0;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_valid ? mem_rdata : '0;
          end
        end
      end

      ST_RELEASE: begin
        if (!owner_req && !mem_valid) begin
          if_valid_d = 1'b0;
          ls_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      owner_q         <= OWN_IF;
      last_q          <= OWN_LS;
      cnt_q           <= '0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
      if_valid        <= 1'b0;
      if_rdata        <= '0;
      ls_valid        <= 1'b0;
      ls_rdata        <= '0;
      timeout_err     <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      last_q          <= last_d;
      cnt_q           <= cnt_d;
      mem_req         <= mem_req_d;
      mem_we          <= mem_we_d;
      mem_addr        <= mem_addr_d;
      mem_wdata       <= mem_wdata_d;
      mem_byte_enable <= mem_be_d;
      if_valid        <= if_valid_d;
      if_rdata        <= if_rdata_d;
      ls_valid        <= ls_valid_d;
      ls_rdata        <= ls_rdata_d;
      timeout_err     <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; the memory side is driven by hand.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_byte_enable;
  logic        ls_valid;
  logic [31:0] ls_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .BYTE_DATA_WIDTH (4),
    .TIMEOUT_CYCLES  (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .if_req          (if_req),
    .if_addr         (if_addr),
    .if_valid        (if_valid),
    .if_rdata        (if_rdata),
    .ls_req          (ls_req),
    .ls_we           (ls_we),
    .ls_addr         (ls_addr),
    .ls_wdata        (ls_wdata),
    .ls_byte_enable  (ls_byte_enable),
    .ls_valid        (ls_valid),
    .ls_rdata        (ls_rdata),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_valid       (mem_valid),
    .mem_rdata       (mem_rdata),
    .timeout_err     (timeout_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"},  {31'd0, mem_req}, 32'd0);
    chk({tag, "_mem_we"},   {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wd"},   mem_wdata, 32'd0);
    chk({tag, "_mem_be"},   {28'd0, mem_byte_enable}, 32'd0);
    chk({tag, "_if_v"},     {31'd0, if_valid}, 32'd0);
    chk({tag, "_if_rd"},    if_rdata, 32'd0);
    chk({tag, "_ls_v"},     {31'd0, ls_valid}, 32'd0);
    chk({tag, "_ls_rd"},    ls_rdata, 32'd0);
    chk({tag, "_terr"},     {31'd0, timeout_err}, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_byte_enable = '0;
    mem_valid = 1'b0; mem_rdata = '0;
    #3;
    chk_all_zero("reset");
    step(); step();
    rst = 1'b1;

    // Fetch only, memory answers three cycles after mem_req
    if_req = 1'b1; if_addr = 32'h100;
    step();
    chk("f_mem_req",  {31'd0, mem_req}, 32'd1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_we",   {31'd0, mem_we}, 32'd0);
    chk("f_mem_be",   {28'd0, mem_byte_enable}, 32'hF);
    chk("f_if_v0",    {31'd0, if_valid}, 32'd0);
    step(); step();
    chk("f_mem_req_hold", {31'd0, mem_req}, 32'd1);
    mem_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    chk("f_if_v",     {31'd0, if_valid}, 32'd1);
    chk("f_if_rd",    if_rdata, 32'hDEADBEEF);
    chk("f_mem_req0", {31'd0, mem_req}, 32'd0);
    mem_valid = 1'b0; mem_rdata = '0;
    step();
    chk("f_if_v_hold", {31'd0, if_valid}, 32'd1);
    chk("f_if_rd_hold", if_rdata, 32'hDEADBEEF);
    if_req = 1'b0;
    step();
    chk("f_if_v_clr", {31'd0, if_valid}, 32'd0);
    step();
    chk("f_idle_no_req", {31'd0, mem_req}, 32'd0);

    // Simultaneous requests right after reset: fetch first, then the store
    rst = 1'b0; #2; rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h300;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'h55; ls_byte_enable = 4'h1;
    step();
    chk("s_first_addr", mem_addr, 32'h300);
    chk("s_first_we",   {31'd0, mem_we}, 32'd0);
    mem_valid = 1'b1; mem_rdata = 32'h12345678;
    step();
    chk("s_if_v",  {31'd0, if_valid}, 32'd1);
    chk("s_if_rd", if_rdata, 32'h12345678);
    chk("s_ls_v0", {31'd0, ls_valid}, 32'd0);
    if_req = 1'b0; mem_valid = 1'b0;
    step();
    chk("s_if_v_clr", {31'd0, if_valid}, 32'd0);
    chk("s_gap_req",  {31'd0, mem_req}, 32'd0);
    step();
    chk("s_st_req",  {31'd0, mem_req}, 32'd1);
    chk("s_st_we",   {31'd0, mem_we}, 32'd1);
    chk("s_st_addr", mem_addr, 32'h200);
    chk("s_st_wd",   mem_wdata, 32'h55);
    chk("s_st_be",   {28'd0, mem_byte_enable}, 32'h1);
    mem_valid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    step();
    chk("s_ls_v",  {31'd0, ls_valid}, 32'd1);
    chk("s_ls_rd", ls_rdata, 32'd0);
    ls_req = 1'b0; mem_valid = 1'b0;
    step();
    chk("s_ls_v_clr", {31'd0, ls_valid}, 32'd0);

    // Continuous contention: last grant was LS, so IF, LS, IF, ... alternate
    if_addr = 32'h1000; ls_addr = 32'h2000; ls_we = 1'b0; ls_byte_enable = 4'hF;
    if_req = 1'b1; ls_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("c_grant_addr", mem_addr, (i % 2 == 0) ? 32'h1000 : 32'h2000);
      mem_valid = 1'b1; mem_rdata = 32'hA0 + i;
      step();
      chk("c_if_v", {31'd0, if_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("c_ls_v", {31'd0, ls_valid}, (i % 2 == 0) ? 32'd0 : 32'd1);
      mem_valid = 1'b0;
      if (i % 2 == 0) if_req = 1'b0; else ls_req = 1'b0;
      step();
      if_req = 1'b1; ls_req = 1'b1;
    end
    chk("c_last_ls_rd", ls_rdata, 32'hA7);
    if_req = 1'b0; ls_req = 1'b0;
    step();

    // Timeout: load never answered, TIMEOUT_CYCLES = 4
    chk("t_err_before", {31'd0, timeout_err}, 32'd0);
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h400;
    step();
    chk("t_mem_req", {31'd0, mem_req}, 32'd1);
    step(); step(); step();
    chk("t_mem_req_b4", {31'd0, mem_req}, 32'd1);
    step();
    chk("t_mem_req0", {31'd0, mem_req}, 32'd0);
    chk("t_ls_v",     {31'd0, ls_valid}, 32'd1);
    chk("t_ls_rd",    ls_rdata, 32'd0);
    chk("t_err",      {31'd0, timeout_err}, 32'd1);
    ls_req = 1'b0;
    step();
    chk("t_ls_v_clr", {31'd0, ls_valid}, 32'd0);
    chk("t_err_sticky", {31'd0, timeout_err}, 32'd1);

    // Asynchronous reset in the middle of BUSY
    if_req = 1'b1; if_addr = 32'h500;
    step();
    chk("r_busy_req", {31'd0, mem_req}, 32'd1);
    #2; rst = 1'b0;
    #1;
    chk_all_zero("r_async");
    #1; rst = 1'b1;
    step();
    chk("r_re_addr", mem_addr, 32'h500);
    chk("r_re_req",  {31'd0, mem_req}, 32'd1);
    mem_valid = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    chk("r_if_v",  {31'd0, if_valid}, 32'd1);
    chk("r_if_rd", if_rdata, 32'hCAFEF00D);
    if_req = 1'b0; mem_valid = 1'b0;
    step();

    // Late mem_valid holds RELEASE; the pending load goes next
    if_req = 1'b1; if_addr = 32'h600;
    step();
    chk("l_if_addr", mem_addr, 32'h600);
    ls_req = 1'b1; ls_addr = 32'h700;
    mem_valid = 1'b1; mem_rdata = 32'h11;
    step();
    chk("l_if_v", {31'd0, if_valid}, 32'd1);
    if_req = 1'b0;
    step();
    chk("l_hold1_v",   {31'd0, if_valid}, 32'd1);
    chk("l_hold1_req", {31'd0, mem_req}, 32'd0);
    step();
    chk("l_hold2_v",   {31'd0, if_valid}, 32'd1);
    chk("l_hold2_req", {31'd0, mem_req}, 32'd0);
    mem_valid = 1'b0;
    step();
    chk("l_idle_v",   {31'd0, if_valid}, 32'd0);
    chk("l_idle_req", {31'd0, mem_req}, 32'd0);
    step();
    chk("l_ls_req",  {31'd0, mem_req}, 32'd1);
    chk("l_ls_addr", mem_addr, 32'h700);
    mem_valid = 1'b1; mem_rdata = 32'h77;
    step();
    chk("l_ls_v",  {31'd0, ls_valid}, 32'd1);
    chk("l_ls_rd", ls_rdata, 32'h77);
    chk("l_if_v0", {31'd0, if_valid}, 32'd0);
    ls_req = 1'b0; mem_valid = 1'b0;
    step();

    // Stale mem_valid while idle is ignored
    mem_valid = 1'b1; mem_rdata = 32'hBAD;
    step(); step();
    chk("i_stale_req", {31'd0, mem_req}, 32'd0);
    chk("i_stale_ifv", {31'd0, if_valid}, 32'd0);
    chk("i_stale_lsv", {31'd0, ls_valid}, 32'd0);
    mem_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
